// File: rtl/arya_pc_pkg.sv
// arya_pc_pkg: shared state encoding, redirect priorities and defaults for PC fetch control
package arya_pc_pkg;
    localparam int DEF_INST_ADDR_WIDTH = 9;
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_BOOT   = 3'd1,
        ST_RUN    = 3'd2,
        ST_FLUSH  = 3'd3,
        ST_HALTED = 3'd4
    } state_t;
    typedef enum logic [2:0] {
        SRC_NONE = 3'd0,
        SRC_RET  = 3'd1,
        SRC_BR   = 3'd2,
        SRC_CALL = 3'd3,
        SRC_JMP  = 3'd4
    } redir_src_t;
endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack with saturating count; a push into a full stack overwrites the oldest entry
module pc_ras #(
    parameter int W     = 9,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] top,
    output logic         empty,
    output logic         full,
    output logic         overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] ptr_q, ptr_d, top_idx;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    assign top_idx  = ptr_q - 1'b1;
    assign top      = mem_q[top_idx];
    assign empty    = cnt_q == '0;
    assign full     = cnt_q == CW'(DEPTH);
    assign overflow = ovf_q;
    // next-state: clear wins, then push (write at pointer), then pop (step pointer back)
    always_comb begin
        mem_d = mem_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        ovf_d = 1'b0;
        if (clear) begin
            ptr_d = '0;
            cnt_d = '0;
        end else if (push) begin
            mem_d[ptr_q] = push_data;
            ptr_d        = ptr_q + 1'b1;
            cnt_d        = full ? cnt_q : cnt_q + 1'b1;
            ovf_d        = full;
        end else if (pop && !empty) begin
            ptr_d = top_idx;
            cnt_d = cnt_q - 1'b1;
        end
    end
    // state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q <= '{default: '0};
            ptr_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            mem_q <= mem_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end
endmodule

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: sequences the PC incrementor through boot, fetch, stall, redirects and halt
module pc_fetch_ctrl
    import arya_pc_pkg::*;
#(
    parameter int                     INST_ADDR_WIDTH = DEF_INST_ADDR_WIDTH,
    parameter int                     RAS_DEPTH       = 4,
    parameter logic [INST_ADDR_WIDTH-1:0] BOOT_ADDR   = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       halt_req,
    input  logic                       stall,
    input  logic                       br_taken,
    input  logic [INST_ADDR_WIDTH-1:0] br_target,
    input  logic                       jmp,
    input  logic                       call,
    input  logic [INST_ADDR_WIDTH-1:0] jmp_target,
    input  logic                       ret,
    input  logic [INST_ADDR_WIDTH-1:0] pc_cur,
    output logic                       pc_en,
    output logic                       pc_wen,
    output logic [INST_ADDR_WIDTH-1:0] pc_next,
    output logic                       flush,
    output logic                       fetch_valid,
    output logic                       running,
    output logic                       ras_overflow,
    output logic                       ras_underflow
);
    localparam int W = INST_ADDR_WIDTH;
    state_t     state_q, state_d;
    redir_src_t src;
    logic         running_q, running_d, underflow_q, underflow_d;
    logic         ras_push, ras_pop, ras_clear, ras_empty, ras_full_unused;
    logic [W-1:0] ras_top, target;
    pc_ras #(.W(W), .DEPTH(RAS_DEPTH)) u_ras (
        .clk       (clk),
        .reset     (reset),
        .clear     (ras_clear),
        .push      (ras_push),
        .push_data (pc_cur + 1'b1),
        .pop       (ras_pop),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full_unused),
        .overflow  (ras_overflow)
    );
    assign running       = running_q;
    assign ras_underflow = underflow_q;
    // highest-priority redirect source below halt, and its target
    always_comb begin
        src    = ret ? SRC_RET : br_taken ? SRC_BR : call ? SRC_CALL : jmp ? SRC_JMP : SRC_NONE;
        target = (src == SRC_RET) ? ras_top : (src == SRC_BR) ? br_target : jmp_target;
    end
    // next-state and Mealy outputs to the incrementor and pipeline
    always_comb begin
        state_d     = state_q;
        underflow_d = underflow_q;
        pc_en       = 1'b0;
        pc_wen      = 1'b0;
        pc_next     = '0;
        flush       = 1'b0;
        fetch_valid = 1'b0;
        ras_push    = 1'b0;
        ras_pop     = 1'b0;
        ras_clear   = 1'b0;
        case (state_q)
            ST_IDLE, ST_HALTED: begin
                if (start) begin
                    state_d     = ST_BOOT;
                    ras_clear   = 1'b1;
                    underflow_d = 1'b0;
                end
            end
            ST_BOOT: begin
                pc_en   = 1'b1;
                pc_wen  = 1'b1;
                pc_next = BOOT_ADDR;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (halt_req) begin
                    state_d = ST_HALTED;
                end else if (src == SRC_RET && ras_empty) begin
                    underflow_d = 1'b1;
                    state_d     = ST_HALTED;
                end else if (src != SRC_NONE) begin
                    pc_en    = 1'b1;
                    pc_wen   = 1'b1;
                    pc_next  = target;
                    flush    = 1'b1;
                    ras_pop  = src == SRC_RET;
                    ras_push = src == SRC_CALL;
                    state_d  = ST_FLUSH;
                end else if (!stall) begin
                    pc_en       = 1'b1;
                    fetch_valid = 1'b1;
                end
            end
            ST_FLUSH: state_d = halt_req ? ST_HALTED : ST_RUN;
            default:  state_d = ST_IDLE;
        endcase
        running_d = state_q == ST_BOOT || state_q == ST_RUN || state_q == ST_FLUSH;
    end
    // state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            running_q   <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            running_q   <= running_d;
            underflow_q <= underflow_d;
        end
    end
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: directed self-checking bench with a behavioural PC incrementor
module tb_pc_fetch_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 0, halt_req = 0, stall = 0, br_taken = 0, jmp = 0, call = 0, ret = 0;
    logic [8:0] br_target = '0, jmp_target = '0, pc_cur, pc_next;
    logic       pc_en, pc_wen, flush, fetch_valid, running, ras_overflow, ras_underflow;
    int         checks = 0, errors = 0;

    pc_fetch_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .halt_req(halt_req), .stall(stall),
        .br_taken(br_taken), .br_target(br_target), .jmp(jmp), .call(call),
        .jmp_target(jmp_target), .ret(ret), .pc_cur(pc_cur), .pc_en(pc_en),
        .pc_wen(pc_wen), .pc_next(pc_next), .flush(flush), .fetch_valid(fetch_valid),
        .running(running), .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
    );

    always #5 clk = ~clk;

    // incrementor the controller drives
    always_ff @(posedge clk) begin
        if (reset) pc_cur <= '0;
        else if (pc_en) pc_cur <= pc_wen ? pc_next : pc_cur + 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        cyc(); cyc();
        reset = 1'b0;
        settle();
        chk("rst_en", pc_en, 0); chk("rst_run", running, 0); chk("rst_fv", fetch_valid, 0);
        chk("rst_unf", ras_underflow, 0); chk("rst_ovf", ras_overflow, 0);
        start = 1'b1; settle();
        chk("idle_en", pc_en, 0);
        cyc(); start = 1'b0; settle();
        chk("boot_en", pc_en, 1); chk("boot_wen", pc_wen, 1); chk("boot_next", pc_next, 0);
        chk("boot_fv", fetch_valid, 0); chk("boot_run", running, 0);
        cyc();
        chk("run_pc0", pc_cur, 0); chk("run_fv", fetch_valid, 1); chk("run_wen", pc_wen, 0);
        chk("run_next", pc_next, 0); chk("run_running", running, 1);
        for (int i = 1; i <= 5; i++) begin
            cyc();
            chk("seq_pc", pc_cur, i);
        end
        // stall then branch during the stall
        stall = 1'b1; settle();
        chk("stall_en", pc_en, 0); chk("stall_fv", fetch_valid, 0);
        cyc(); chk("stall_pc1", pc_cur, 5);
        cyc(); chk("stall_pc2", pc_cur, 5);
        br_taken = 1'b1; br_target = 9'h40; settle();
        chk("br_flush", flush, 1); chk("br_wen", pc_wen, 1); chk("br_next", pc_next, 9'h40);
        chk("br_fv", fetch_valid, 0);
        cyc(); br_taken = 1'b0; stall = 1'b0; settle();
        chk("fl_pc", pc_cur, 9'h40); chk("fl_en", pc_en, 0); chk("fl_fv", fetch_valid, 0);
        cyc(); chk("br_resume_pc", pc_cur, 9'h40); chk("br_resume_fv", fetch_valid, 1);
        cyc(); chk("br_next_pc", pc_cur, 9'h41);
        // call / return
        jmp = 1'b1; jmp_target = 9'h10; settle();
        chk("jmp_next", pc_next, 9'h10);
        cyc(); jmp = 1'b0; cyc();
        chk("jmp_pc", pc_cur, 9'h10);
        call = 1'b1; jmp_target = 9'h80; settle();
        chk("call_next", pc_next, 9'h80); chk("call_flush", flush, 1);
        cyc(); call = 1'b0; settle();
        chk("call_pc", pc_cur, 9'h80);
        cyc();
        ret = 1'b1; settle();
        chk("ret_next", pc_next, 9'h11);
        cyc(); ret = 1'b0; settle();
        chk("ret_pc", pc_cur, 9'h11);
        cyc();
        // nested calls beyond depth
        for (int i = 0; i < 5; i++) begin
            call = 1'b1; jmp_target = 9'(9'h20 + 16 * i);
            cyc(); call = 1'b0; settle();
            chk("nest_ovf", ras_overflow, (i == 4) ? 1 : 0);
            cyc();
            chk("nest_ovf_clr", ras_overflow, 0);
            chk("nest_pc", pc_cur, 9'h20 + 16 * i);
        end
        for (int i = 0; i < 4; i++) begin
            ret = 1'b1; settle();
            chk("lifo_next", pc_next, 9'h51 - 16 * i);
            cyc(); ret = 1'b0; cyc();
            chk("lifo_pc", pc_cur, 9'h51 - 16 * i);
        end
        ret = 1'b1; settle();
        chk("unf_wen", pc_wen, 0); chk("unf_flush", flush, 0);
        cyc(); ret = 1'b0; settle();
        chk("unf_sticky", ras_underflow, 1); chk("halt_en", pc_en, 0); chk("halt_pc", pc_cur, 9'h21);
        cyc();
        chk("halt_running", running, 0); chk("halt_pc2", pc_cur, 9'h21); chk("unf_hold", ras_underflow, 1);
        // restart, then simultaneous events
        start = 1'b1; cyc(); start = 1'b0; settle();
        chk("restart_unf", ras_underflow, 0);
        cyc(); chk("restart_pc", pc_cur, 0);
        call = 1'b1; jmp_target = 9'h70; cyc(); call = 1'b0; cyc();
        chk("c2_pc", pc_cur, 9'h70);
        br_taken = 1'b1; br_target = 9'h90; call = 1'b1; jmp_target = 9'h55; settle();
        chk("brcall_next", pc_next, 9'h90);
        cyc(); br_taken = 1'b0; call = 1'b0; cyc();
        chk("brcall_pc", pc_cur, 9'h90);
        ret = 1'b1; settle();
        chk("nopush_next", pc_next, 9'h01);
        cyc(); ret = 1'b0; cyc();
        chk("nopush_pc", pc_cur, 9'h01);
        halt_req = 1'b1; ret = 1'b1; br_taken = 1'b1; call = 1'b1; settle();
        chk("all_wen", pc_wen, 0); chk("all_flush", flush, 0); chk("all_en", pc_en, 0);
        cyc(); halt_req = 1'b0; ret = 1'b0; br_taken = 1'b0; call = 1'b0; settle();
        chk("all_pc", pc_cur, 9'h01); chk("all_unf", ras_underflow, 0); chk("all_halt_en", pc_en, 0);
        // reset during FLUSH
        start = 1'b1; cyc(); start = 1'b0; cyc();
        call = 1'b1; jmp_target = 9'h30; cyc(); call = 1'b0;
        reset = 1'b1; cyc(); reset = 1'b0; settle();
        chk("mrst_en", pc_en, 0); chk("mrst_run", running, 0); chk("mrst_flush", flush, 0);
        chk("mrst_wen", pc_wen, 0); chk("mrst_fv", fetch_valid, 0);
        start = 1'b1; cyc(); start = 1'b0; settle();
        chk("mrst_boot_next", pc_next, 0); chk("mrst_boot_wen", pc_wen, 1);
        cyc(); chk("mrst_pc", pc_cur, 0);
        ret = 1'b1; settle();
        chk("mrst_empty_wen", pc_wen, 0);
        cyc(); ret = 1'b0; settle();
        chk("mrst_empty_unf", ras_underflow, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pc_fetch_ctrl.md
# pc_fetch_ctrl

Sequencing controller for the per-core PC incrementor: drives its `en`/`wen`/`pc_in` inputs to implement boot, sequential fetch, stall, branch/jump/call/return redirects and halt. It contains a small return-address stack (RAS) for call/return. It sits between the decode/execute control signals and the PC register, and produces the fetch-valid and flush qualifiers consumed by the fetch/decode pipeline registers.

## Interface
Parameters:
- `INST_ADDR_WIDTH`, 9: width of the PC and all targets.
- `RAS_DEPTH`, 4: number of RAS entries, power of two, ≥2.
- `BOOT_ADDR`, 0: PC written on boot.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  leave IDLE/HALTED and boot.
- `halt_req`  in  1  halt instruction decoded.
- `stall`  in  1  pipeline stall, hold PC.
- `br_taken`  in  1  conditional branch resolved taken.
- `br_target`  in  W  branch target.
- `jmp`  in  1  unconditional jump.
- `call`  in  1  jump plus push return address; uses `jmp_target`.
- `jmp_target`  in  W  jump/call target.
- `ret`  in  1  return, pop RAS.
- `pc_cur`  in  W  current PC from the incrementor output.
- `pc_en`  out  1  to incrementor `en`.
- `pc_wen`  out  1  to incrementor `wen`.
- `pc_next`  out  W  to incrementor `pc_in`.
- `flush`  out  1  kill the instruction in flight.
- `fetch_valid`  out  1  instruction fetched at `pc_cur` is valid.
- `running`  out  1  registered; 1 in BOOT/RUN/FLUSH.
- `ras_overflow`  out  1  one-cycle pulse on push into a full RAS.
- `ras_underflow`  out  1  sticky; set on `ret` with empty RAS, cleared by `start` or `reset`.

## Operation
- States: IDLE, BOOT, RUN, FLUSH, HALTED. On reset the controller enters IDLE, the RAS is emptied, and every output is 0.
- IDLE: all outputs 0. `start` moves to BOOT.
- BOOT: `pc_en=1`, `pc_wen=1`, `pc_next=BOOT_ADDR`, `fetch_valid=0`. Always moves to RUN.
- RUN: inputs are evaluated in strict priority order:
  1. `halt_req`: `pc_en=0`, `fetch_valid=0`; moves to HALTED.
  2. `ret`:
     - RAS non-empty: pop, redirect to the popped address.
     - RAS empty: set `ras_underflow`, move to HALTED, no redirect.
  3. `br_taken`: redirect to `br_target`.
  4. `call`: push `pc_cur+1` (mod 2^W), redirect to `jmp_target`.
  5. `jmp`: redirect to `jmp_target`.
  6. `stall`: `pc_en=0`, `fetch_valid=0`.
  7. Otherwise: `pc_en=1`, `pc_wen=0`, `fetch_valid=1`.
- Redirect means `pc_en=1`, `pc_wen=1`, `pc_next=target`, `flush=1`, `fetch_valid=0`, then move to FLUSH. A redirect overrides `stall`. A lower-priority request in the same cycle is dropped (no push or pop).
- FLUSH: exactly one bubble cycle for the synchronous instruction-memory latency. `pc_en=0`, `fetch_valid=0`. All redirect inputs are ignored. `halt_req` moves to HALTED; otherwise move to RUN.
- HALTED: `pc_en=0`; PC and RAS are held. `start` moves to BOOT, clears `ras_underflow`, and empties the RAS.
- `pc_next` is 0 whenever `pc_wen=0`.
- RAS behaviour:
  - Circular buffer with a saturating count.
  - Push when full overwrites the oldest entry, keeps count at `RAS_DEPTH`, and pulses `ras_overflow`.
  - Pop returns the most recent entry.

## Timing
- `pc_en`, `pc_wen`, `pc_next`, `flush` and `fetch_valid` are combinational from state and inputs (Mealy). The incrementor provides the register stage.
- Redirect asserted in cycle N: `pc_cur` equals the target in N+1 (FLUSH), and `fetch_valid=1` resumes in N+2.
- After `start` in cycle N: BOOT occurs in N+1, and `pc_cur=BOOT_ADDR` in N+2 with RUN active.
- `running` and `ras_overflow` are registered; they reflect the state/event of the previous cycle.
- `reset` mid-operation takes effect on the next edge regardless of state.

## Structure
- Shared package `arya_pc_pkg` holds:
  - the state encoding constants (IDLE=0, BOOT=1, RUN=2, FLUSH=3, HALTED=4, 3-bit);
  - the redirect-source priority constants;
  - the default `INST_ADDR_WIDTH`.
- One sub-module, `pc_ras`:
  - Ports: `clk`, `reset`, `clear`, `push`, `push_data`, `pop`, `top`, `empty`, `full`, `overflow`.
  - `push` and `pop` are never asserted together.
- The FSM, priority mux and output logic live in `pc_fetch_ctrl`.

## Test plan
- Boot and sequential run: reset, `start` at cycle 2 → `pc_wen` pulse with `pc_next=0` at cycle 3; `pc_cur` counts 0,1,2,… from cycle 4 with `fetch_valid=1`.
- Stall then branch: 3-cycle `stall` holds `pc_cur=5`; `br_taken` with `br_target=0x40` during the stall → `flush=1`, `pc_cur=0x40` next cycle, one bubble, then 0x41.
- Call/return: `call` at `pc_cur=0x10` with `jmp_target=0x80` → PC becomes 0x80; later `ret` → PC becomes 0x11.
- Nested calls beyond depth: 5 calls with `RAS_DEPTH=4` → `ras_overflow` pulse on the 5th; four returns succeed in LIFO order; a 5th `ret` sets `ras_underflow` and enters HALTED.
- Simultaneous events: `halt_req`, `ret`, `br_taken` and `call` all asserted together → HALTED with no redirect and RAS count unchanged. `br_taken` and `call` together → branch taken, no push.
- Reset mid-FLUSH: assert `reset` during the FLUSH cycle → next cycle IDLE with all outputs 0 and the RAS empty; the following `start` boots to `BOOT_ADDR`.
